// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-redirect branch predictor.
package bp_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MAX_TAG_W = 30;

    // 2-bit direction counter states; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    localparam logic [XLEN-1:0] STAT_MAX = 32'hFFFF_FFFF;

    // Tag field is sized for the widest legal tag; narrower tags are zero-extended
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [XLEN-1:0]      target;
        ctr_e                 ctr;
    } btb_entry_t;

    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
        return (v == STAT_MAX) ? v : v + XLEN'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup, EX resolution and statistics signals between the pipeline and the predictor.
interface branch_predictor_if;
    import bp_pkg::*;

    logic [XLEN-1:0] if_pc;
    logic            prediction;
    logic [XLEN-1:0] control_pc;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_is_branch;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred;
    logic [XLEN-1:0] ex_pred_pc;

    logic            flush;
    logic [XLEN-1:0] pc_branch;

    logic [XLEN-1:0] branch_cnt;
    logic [XLEN-1:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target, ex_pred, ex_pred_pc,
        input  prediction, control_pc, flush, pc_branch, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target, ex_pred, ex_pred_pc,
        output prediction, control_pc, flush, pc_branch, branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter, next-state only.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_inc,
    output ctr_e o_ctr_c
);

    always_comb begin
        o_ctr_c = i_ctr;
        if (i_inc) begin
            if (i_ctr != ST) o_ctr_c = ctr_e'(2'(i_ctr) + 2'd1);
        end else begin
            if (i_ctr != SNT) o_ctr_c = ctr_e'(2'(i_ctr) - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; drives IF prediction and EX mispredict flush.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;

    btb_entry_t r_btb [ENTRIES];

    logic [XLEN-1:0] r_branch_cnt;
    logic [XLEN-1:0] r_mispred_cnt;

    logic [IDX_W-1:0]     w_if_idx;
    logic [MAX_TAG_W-1:0] w_if_tag;
    btb_entry_t           w_if_entry;
    logic                 w_if_hit;
    logic                 w_prediction;

    logic [IDX_W-1:0]     w_ex_idx;
    logic [MAX_TAG_W-1:0] w_ex_tag;
    btb_entry_t           w_ex_entry;
    logic                 w_ex_hit;
    ctr_e                 w_ctr_next;

    logic                 w_resolve;
    logic                 w_flush;
    logic [XLEN-1:0]      w_pc_branch;

    // Byte-offset bits never take part in indexing or tagging
    logic w_unused_ok;
    assign w_unused_ok = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

    assign w_if_idx = bus.if_pc[2 +: IDX_W];
    assign w_if_tag = MAX_TAG_W'(bus.if_pc[TAG_LO +: TAG_W]);
    assign w_ex_idx = bus.ex_pc[2 +: IDX_W];
    assign w_ex_tag = MAX_TAG_W'(bus.ex_pc[TAG_LO +: TAG_W]);

    // Asynchronous-read lookup for the fetch PC
    always_comb begin
        w_if_entry   = r_btb[w_if_idx];
        w_if_hit     = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
        w_prediction = w_if_hit && w_if_entry.ctr[1];
    end

    always_comb begin
        w_ex_entry = r_btb[w_ex_idx];
        w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
    end

    // Mispredict detection: wrong direction, wrong target, or a prediction on a non-branch
    always_comb begin
        w_resolve   = bus.ex_valid && bus.ex_is_branch;
        w_flush     = 1'b0;
        w_pc_branch = '0;
        if (w_resolve && (bus.ex_taken != bus.ex_pred)) w_flush = 1'b1;
        if (w_resolve && bus.ex_taken && bus.ex_pred && (bus.ex_target != bus.ex_pred_pc))
            w_flush = 1'b1;
        if (bus.ex_valid && !bus.ex_is_branch && bus.ex_pred) w_flush = 1'b1;
        if (w_flush)
            w_pc_branch = (w_resolve && bus.ex_taken) ? bus.ex_target : bus.ex_pc + XLEN'(4);
    end

    bp_sat_counter u_sat_counter (
        .i_ctr   (w_ex_entry.ctr),
        .i_inc   (bus.ex_taken),
        .o_ctr_c (w_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (bus.ex_valid) begin
            if (bus.ex_is_branch) begin
                if (w_ex_hit) begin
                    r_btb[w_ex_idx].ctr <= w_ctr_next;
                    if (bus.ex_taken) r_btb[w_ex_idx].target <= bus.ex_target;
                end else if (bus.ex_taken) begin
                    r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag,
                                         target: bus.ex_target, ctr: CTR_ALLOC};
                end
            end else if (w_ex_hit) begin
                // A non-branch that hits means a stale alias; drop it
                r_btb[w_ex_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve) r_branch_cnt  <= sat_inc(r_branch_cnt);
            if (w_flush)   r_mispred_cnt <= sat_inc(r_mispred_cnt);
        end
    end

    assign bus.prediction  = w_prediction;
    assign bus.control_pc  = w_prediction ? w_if_entry.target : '0;
    assign bus.flush       = w_flush;
    assign bus.pc_branch   = w_pc_branch;
    assign bus.branch_cnt  = r_branch_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, mispredict flush, table update and statistics.
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(16), .TAG_W(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex_drive(input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic pr, input logic [31:0] prpc);
        bus.ex_valid     = v;
        bus.ex_is_branch = br;
        bus.ex_pc        = pc;
        bus.ex_taken     = tk;
        bus.ex_target    = tgt;
        bus.ex_pred      = pr;
        bus.ex_pred_pc   = prpc;
    endtask

    task automatic ex_idle();
        ex_drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic pred, input logic [31:0] cpc);
        bus.if_pc = pc;
        #1;
        chk({tag, "_pred"}, 32'(bus.prediction), 32'(pred));
        chk({tag, "_cpc"}, bus.control_pc, cpc);
    endtask

    task automatic flushchk(input string tag, input logic fl, input logic [31:0] pcb);
        #1;
        chk({tag, "_flush"}, 32'(bus.flush), 32'(fl));
        chk({tag, "_pcb"}, bus.pc_branch, pcb);
    endtask

    task automatic cnts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, "_bcnt"}, bus.branch_cnt, bc);
        chk({tag, "_mcnt"}, bus.mispred_cnt, mc);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.if_pc = 32'h100;
        ex_idle();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        look("rst_hold", 32'h100, 1'b0, 32'h0);
        cnts("rst_hold", 32'd0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        look("rst_rel", 32'h100, 1'b0, 32'h0);
        flushchk("rst_rel", 1'b0, 32'h0);
        cnts("rst_rel", 32'd0, 32'd0);

        // Cold taken branch allocates; same-cycle lookup still sees the old table
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        look("cold_same", 32'h40, 1'b0, 32'h0);
        flushchk("cold", 1'b1, 32'h80);
        step();
        ex_idle();
        look("cold_next", 32'h40, 1'b1, 32'h80);
        cnts("cold", 32'd1, 32'd1);

        // One not-taken drops WT to WNT
        ex_drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        flushchk("hyst", 1'b1, 32'h44);
        step();
        ex_idle();
        look("hyst_next", 32'h40, 1'b0, 32'h0);
        cnts("hyst", 32'd2, 32'd2);

        // Climb back to ST: WNT->WT (mispredicted), WT->ST (correct)
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        flushchk("climb1", 1'b1, 32'h80);
        step();
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        flushchk("climb2", 1'b0, 32'h0);
        step();

        // Wrong target with ST: counter saturates, target replaced
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
        flushchk("wtgt", 1'b1, 32'hC0);
        step();
        ex_idle();
        look("wtgt_next", 32'h40, 1'b1, 32'hC0);
        cnts("wtgt", 32'd5, 32'd4);

        // Single not-taken from saturated ST still predicts taken
        ex_drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'hC0);
        flushchk("sat_nt", 1'b1, 32'h44);
        step();
        ex_idle();
        look("sat_nt_next", 32'h40, 1'b1, 32'hC0);

        // Non-branch alias flushes and invalidates the entry
        ex_drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'hC0);
        flushchk("alias", 1'b1, 32'h44);
        step();
        ex_idle();
        look("alias_next", 32'h40, 1'b0, 32'h0);
        cnts("alias", 32'd6, 32'd6);

        // Re-allocate, then probe same index with a different tag
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        ex_idle();
        look("tag_miss", 32'h440, 1'b0, 32'h0);
        look("tag_hit", 32'h40, 1'b1, 32'h80);

        // pc+4 wraps at the top of the address space; not-taken miss does not allocate
        ex_drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234);
        flushchk("wrap", 1'b1, 32'h0);
        step();
        ex_idle();
        look("wrap_next", 32'hFFFF_FFFC, 1'b0, 32'h0);
        cnts("wrap", 32'd8, 32'd8);

        // Invalid EX slot: no flush, no update, no statistics
        ex_drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h0);
        flushchk("exinv", 1'b0, 32'h0);
        step();
        ex_idle();
        look("exinv_next", 32'h40, 1'b1, 32'h80);
        cnts("exinv", 32'd8, 32'd8);

        // Mispredict counter saturation from a preloaded value
        force dut.r_mispred_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_mispred_cnt;
        ex_drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
        flushchk("sat1", 1'b1, 32'h300);
        step();
        #1;
        cnts("sat1", 32'd9, 32'hFFFF_FFFF);
        step();
        #1;
        cnts("sat2", 32'd10, 32'hFFFF_FFFF);
        ex_idle();
        look("sat_alloc", 32'h100, 1'b1, 32'h300);

        // Asynchronous reset mid-operation clears everything without a clock edge
        ex_drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h400, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        look("arst", 32'h100, 1'b0, 32'h0);
        cnts("arst", 32'd0, 32'd0);
        ex_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        look("arst_after", 32'h100, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-redirect controller for the IF stage PC register. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters and drives the IF controls:
- `prediction`/`control_pc` each cycle from the current fetch PC.
- `flush`/`pc_branch` when the EX stage resolves a mispredicted control transfer.

Table updates come from EX-stage resolution. The block also keeps saturating branch and mispredict statistics counters.

## Interface
Parameters:
- `ENTRIES`, 16: BTB entries, power of two; index = `if_pc[IDX_W+1:2]`, IDX_W = log2(ENTRIES).
- `TAG_W`, 26: tag bits = `pc[IDX_W+2+TAG_W-1 : IDX_W+2]`; with defaults this is `pc[31:6]`.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `if_pc`  in  32: current fetch PC (IF `cpc`).
- `prediction`  out  1: predict taken; IF loads `control_pc`.
- `control_pc`  out  32: predicted target.
- `ex_valid`  in  1: EX holds a real instruction; low for bubbles, stall and halt.
- `ex_pc`  in  32: PC of the EX instruction.
- `ex_is_branch`  in  1: EX instruction is a branch or jump.
- `ex_taken`  in  1: resolved direction.
- `ex_target`  in  32: resolved taken target.
- `ex_pred`  in  1: `prediction` value piped from IF with this instruction.
- `ex_pred_pc`  in  32: `control_pc` value piped from IF.
- `flush`  out  1: redirect IF and kill younger stages.
- `pc_branch`  out  32: correct PC on flush.
- `branch_cnt`  out  32: resolved branches, saturating.
- `mispred_cnt`  out  32: flushes issued, saturating.

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[32]`, `ctr[2]`.
- Reset values:
  - All `valid` = 0, all `ctr` = 2'b01 (weak not-taken), targets and tags = 0.
  - Both statistics counters = 0.
  - All combinational outputs follow from this state: `prediction` = 0, `control_pc` = 0 at reset.
- Lookup (combinational):
  - hit = `valid[idx] && tag[idx] == if_pc tag`.
  - `prediction` = hit && `ctr[idx][1]`.
  - `control_pc` = `target[idx]` when `prediction`, else 0.
- Mispredict detect (combinational, qualified by `ex_valid`). Define r = `ex_valid && ex_is_branch`.
  - r, `ex_taken` != `ex_pred` → flush.
  - r, `ex_taken` && `ex_pred` && `ex_target` != `ex_pred_pc` → flush.
  - `ex_valid`, !`ex_is_branch`, `ex_pred` (alias) → flush.
  - `pc_branch` = (r && `ex_taken`) ? `ex_target` : `ex_pc` + 4. The +4 wraps modulo 2^32.
  - `pc_branch` = 0 whenever `flush` = 0.
- Update at the clock edge, only when `ex_valid`. Index and tag come from `ex_pc`.
  - Branch, hit, taken: `ctr` increments (saturates at 11); `target` ← `ex_target`.
  - Branch, hit, not taken: `ctr` decrements (saturates at 00).
  - Branch, miss, taken: allocate. `valid` = 1, tag written, `target` ← `ex_target`, `ctr` = 2'b10.
  - Branch, miss, not taken: no change.
  - Non-branch that hits: `valid` ← 0.
- Statistics:
  - `branch_cnt` +1 on each resolved branch (r).
  - `mispred_cnt` +1 on each `flush` cycle.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- Lookup has 0-cycle latency. `prediction`/`control_pc` are valid in the same cycle as `if_pc`, so IF samples them at the next edge.
- `flush`/`pc_branch` have 0-cycle latency from the EX inputs. IF gives `flush` priority over stall, halt and `prediction`.
- Table writes take effect at the edge. A same-cycle lookup of the index being written sees the old contents; the next cycle sees the new contents.
- `flush` does not block the table update of the resolving instruction.
- Asynchronous reset mid-operation clears tables and counters immediately. No partial update survives.
- Stall (NOP) and halt are handled by the pipeline holding `ex_valid` low. The block has no stall input.

## Structure
- Package `bp_pkg` holds:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - `CTR_RESET`, `CTR_ALLOC`.
  - The BTB entry struct typedef.
  - The `STAT_MAX` constant.
- Sub-module `bp_sat_counter`: 2-bit saturating increment/decrement, combinational next-state. It is instantiated once in the update path.
- Table storage is flops, not SRAM (asynchronous read is required).

## Test plan
- Reset: hold `rst_n` = 0, then release.
  - `if_pc` = 0x100 → `prediction` = 0, `control_pc` = 0.
  - `flush` = 0, both counters = 0.
- Cold taken branch: EX `ex_pc` = 0x40, taken, target 0x80, `ex_pred` = 0.
  - `flush` = 1, `pc_branch` = 0x80.
  - Next cycle `if_pc` = 0x40 → `prediction` = 1, `control_pc` = 0x80.
- Hysteresis: after allocation (ctr = 10), resolve 0x40 not taken once.
  - `flush` = 1, `pc_branch` = 0x44; ctr becomes 01.
  - Lookup 0x40 → `prediction` = 0.
- Wrong target: entry 0x40 → 0x80 with ctr = 11; resolve taken to 0xC0 with `ex_pred_pc` = 0x80.
  - `flush` = 1, `pc_branch` = 0xC0.
  - Next cycle `control_pc` = 0xC0.
- Alias and tag miss:
  - Non-branch at the same `ex_pc` with `ex_pred` = 1 → `flush` = 1, `pc_branch` = `ex_pc` + 4, entry invalidated.
  - `if_pc` = 0x440 (same index, different tag) → `prediction` = 0.
- Boundaries:
  - `ex_pc` = 0xFFFF_FFFC not taken with `ex_pred` = 1 → `pc_branch` = 0x0.
  - `ex_valid` = 0 with a mismatch present → no flush, no update.
  - `mispred_cnt` preloaded near max stays at 0xFFFF_FFFF.
